// File: rtl/spi_master_tx_engine.sv
// Mode-0 SPI master: pops 41-bit command words from the TX FIFO, shifts them out MSB-first
// and, for read commands, captures the 32-bit data field from MISO into rx_data.
module spi_master_tx_engine #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned FRAME_BITS = 41
) (
  input  logic                  spi_clk,
  input  logic                  spi_rst_n,
  input  logic                  fifo_empty,
  input  logic [FRAME_BITS-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso,
  output logic [31:0]           rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int unsigned DATA_BITS      = 32;
  localparam int unsigned DIV_W          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W          = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned BIT_W          = $clog2(FRAME_BITS + 1);
  localparam int unsigned LAST_BIT       = FRAME_BITS - 1;
  localparam int unsigned FIRST_DATA_BIT = FRAME_BITS - DATA_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e                state_q,    state_d;
  logic [FRAME_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  is_read_q,  is_read_d;
  logic [DIV_W-1:0]      div_cnt_q,  div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,  gap_cnt_d;
  logic                  rd_en_q,    rd_en_d;
  logic                  sclk_q,     sclk_d;
  logic                  cs_n_q,     cs_n_d;
  logic                  mosi_q,     mosi_d;
  logic [DATA_BITS-1:0]  rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q,     busy_d;

  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      rx_shift_q <= '0;
      is_read_q  <= 1'b0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      is_read_q  <= is_read_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rd_en_q    <= rd_en_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    is_read_d  = is_read_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rd_en_d    = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        shift_d   = fifo_rd_data;
        is_read_d = ~fifo_rd_data[LAST_BIT];
        mosi_d    = fifo_rd_data[LAST_BIT];
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: only the trailing 32 bits of a read frame carry data.
            if (is_read_q && (bit_cnt_q >= BIT_W'(FIRST_DATA_BIT))) begin
              rx_shift_d = {rx_shift_q[DATA_BITS-2:0], miso};
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(LAST_BIT)) begin
              cs_n_d    = 1'b1;
              sclk_d    = 1'b0;
              mosi_d    = 1'b0;
              gap_cnt_d = '0;
              state_d   = ST_GAP;
              if (is_read_q) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
              end
            end else begin
              mosi_d  = shift_q[LAST_BIT-1];
              shift_d = {shift_q[LAST_BIT-1:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign fifo_rd_en = rd_en_q;
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_master_tx_engine.sv
// Bench for spi_master_tx_engine: FWFT FIFO model, mode-0 slave model and frame monitors
// for a default instance (CLK_DIV=2, CS_GAP=4) and a fast instance (CLK_DIV=1, CS_GAP=1).
module tb_spi_master_tx_engine;

  logic spi_clk = 1'b0;
  logic spi_rst_n;
  always #5 spi_clk = ~spi_clk;

  logic        fifo_empty_a, fifo_rd_en_a, sclk_a, cs_n_a, mosi_a, rx_valid_a, busy_a;
  logic [40:0] fifo_rd_data_a;
  logic        miso_a = 1'b0;
  logic [31:0] rx_data_a;
  logic        fifo_empty_b, fifo_rd_en_b, sclk_b, cs_n_b, mosi_b, rx_valid_b, busy_b;
  logic [40:0] fifo_rd_data_b;
  logic        miso_b = 1'b0;
  logic [31:0] rx_data_b;

  spi_master_tx_engine #(.CLK_DIV(2), .CS_GAP(4), .FRAME_BITS(41)) u_dut_a (
    .spi_clk(spi_clk), .spi_rst_n(spi_rst_n), .fifo_empty(fifo_empty_a),
    .fifo_rd_data(fifo_rd_data_a), .fifo_rd_en(fifo_rd_en_a), .sclk(sclk_a), .cs_n(cs_n_a),
    .mosi(mosi_a), .miso(miso_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a)
  );

  spi_master_tx_engine #(.CLK_DIV(1), .CS_GAP(1), .FRAME_BITS(41)) u_dut_b (
    .spi_clk(spi_clk), .spi_rst_n(spi_rst_n), .fifo_empty(fifo_empty_b),
    .fifo_rd_data(fifo_rd_data_b), .fifo_rd_en(fifo_rd_en_b), .sclk(sclk_b), .cs_n(cs_n_b),
    .mosi(mosi_b), .miso(miso_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus-side model state (owned by the main initial block)
  logic [40:0] qa[$];
  logic [40:0] qb[$];
  logic [40:0] word_a     [64];
  logic [40:0] resp_arr_a [64];
  logic [31:0] exp_rx_a   [64];
  int n_push_a = 0;
  int exp_n_a  = 0;

  // Monitor state for instance A (owned by its monitor block)
  logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0, prev_mosi_a = 1'b0, prev_rxv_a = 1'b0;
  logic        prev_rden_a = 1'b0, prev_busy_a = 1'b0, prev_empty_a = 1'b1, have_a = 1'b0;
  logic [63:0] cur_bits_a = '0;
  int cur_len_a = 0, cur_rises_a = 0, cur_falls_a = 0, fr_start_a = 0, n_done_a = 0, hi_len_a = 0;
  logic [63:0] fr_bits_a [64];
  int fr_len_a [64], fr_rises_a [64], gap_a [64];
  logic [31:0] rxv_data_mon_a [64];
  int rxv_cnt_a = 0, rxv_bad_a = 0, rden_cnt_a = 0, rden_bad_a = 0, mode_bad_a = 0, busy_cyc_a = 0;

  // Monitor state for instance B
  logic        prev_cs_b = 1'b1, prev_sclk_b = 1'b0;
  logic [63:0] cur_bits_b = '0, fb_bits_b = '0;
  int cur_len_b = 0, cur_rises_b = 0, fb_len_b = 0, fb_rises_b = 0, n_done_b = 0;
  int tog_bad_b = 0, rden_cnt_b = 0;

  always @(negedge spi_clk) begin
    if (!cs_n_a) begin
      if (prev_cs_a) begin
        if (have_a && fr_start_a < 64) gap_a[fr_start_a] = hi_len_a;
        cur_len_a = 0; cur_rises_a = 0; cur_falls_a = 0; cur_bits_a = '0;
        fr_start_a++;
      end
      cur_len_a++;
      if (sclk_a && !prev_sclk_a) begin
        cur_bits_a = {cur_bits_a[62:0], mosi_a};
        cur_rises_a++;
      end
      if (!sclk_a && prev_sclk_a && !prev_cs_a) cur_falls_a++;
      if (!prev_cs_a && (mosi_a !== prev_mosi_a) && !(!sclk_a && prev_sclk_a)) mode_bad_a++;
      // Slave drives the next response bit after each SCLK falling edge
      if (cur_falls_a <= 40 && fr_start_a >= 1 && fr_start_a <= 64)
        miso_a = resp_arr_a[fr_start_a-1][40-cur_falls_a];
      else
        miso_a = 1'b0;
    end else begin
      if (!prev_cs_a) begin
        if (n_done_a < 64) begin
          fr_bits_a[n_done_a]  = cur_bits_a;
          fr_len_a[n_done_a]   = cur_len_a;
          fr_rises_a[n_done_a] = cur_rises_a;
        end
        n_done_a++;
        have_a   = 1'b1;
        hi_len_a = 0;
      end
      hi_len_a++;
      miso_a = 1'b0;
    end
    if (rx_valid_a) begin
      if (rxv_cnt_a < 64) rxv_data_mon_a[rxv_cnt_a] = rx_data_a;
      rxv_cnt_a++;
      if (prev_rxv_a || !(cs_n_a && !prev_cs_a)) rxv_bad_a++;
    end
    if (fifo_rd_en_a) begin
      rden_cnt_a++;
      if (prev_rden_a || prev_busy_a || prev_empty_a) rden_bad_a++;
    end
    if (busy_a) busy_cyc_a++;
    prev_cs_a    = cs_n_a;
    prev_sclk_a  = sclk_a;
    prev_mosi_a  = mosi_a;
    prev_rxv_a   = rx_valid_a;
    prev_rden_a  = fifo_rd_en_a;
    prev_busy_a  = busy_a;
    prev_empty_a = fifo_empty_a;
  end

  always @(negedge spi_clk) begin
    if (!cs_n_b) begin
      if (prev_cs_b) begin
        cur_len_b = 0; cur_rises_b = 0; cur_bits_b = '0;
      end
      cur_len_b++;
      if (sclk_b && !prev_sclk_b) begin
        cur_bits_b = {cur_bits_b[62:0], mosi_b};
        cur_rises_b++;
      end
      if (!prev_cs_b && (sclk_b === prev_sclk_b)) tog_bad_b++;
    end else if (!prev_cs_b) begin
      fb_bits_b  = cur_bits_b;
      fb_len_b   = cur_len_b;
      fb_rises_b = cur_rises_b;
      n_done_b++;
    end
    if (fifo_rd_en_b) rden_cnt_b++;
    prev_cs_b   = cs_n_b;
    prev_sclk_b = sclk_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic upd();
    fifo_empty_a   = (qa.size() == 0);
    fifo_rd_data_a = (qa.size() > 0) ? qa[0] : '0;
    fifo_empty_b   = (qb.size() == 0);
    fifo_rd_data_b = (qb.size() > 0) ? qb[0] : '0;
  endtask

  // One clock; a pop strobe seen before the edge removes the FIFO head after it
  task automatic tick();
    logic pa, pb;
    @(negedge spi_clk);
    pa = fifo_rd_en_a;
    pb = fifo_rd_en_b;
    @(posedge spi_clk);
    #1;
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    upd();
  endtask

  task automatic push_a(input logic [40:0] w, input logic [40:0] r, input bit exp_rx);
    word_a[n_push_a]     = w;
    resp_arr_a[n_push_a] = r;
    n_push_a++;
    if (exp_rx) begin
      exp_rx_a[exp_n_a] = r[31:0];
      exp_n_a++;
    end
    qa.push_back(w);
    upd();
  endtask

  task automatic wait_frames_a(input int target);
    int budget;
    budget = 400 * (target - n_done_a + 1);
    while ((n_done_a < target || busy_a) && budget > 0) begin
      tick();
      budget--;
    end
    chk($sformatf("wait_frames_%0d", target), 64'(n_done_a >= target && !busy_a), 64'(1));
  endtask

  task automatic chk_frame_a(input int i);
    chk($sformatf("mosi_bits_f%0d", i), fr_bits_a[i], {23'b0, word_a[i]});
    chk($sformatf("cs_low_len_f%0d", i), 64'(fr_len_a[i]), 64'(164));
    chk($sformatf("sclk_rises_f%0d", i), 64'(fr_rises_a[i]), 64'(41));
  endtask

  typedef struct {
    logic [40:0] word;
    logic [40:0] resp;
    logic        exp_rxv;
    logic [31:0] exp_rx;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    int          base, rv0, rd0, budget;
    logic [40:0] w, r;

    tbl[0] = '{41'h1_A5_DEADBEEF, 41'h1_FF_CAFEF00D, 1'b0, 32'h0000_0000};
    tbl[1] = '{41'h0_3C_00000000, 41'h1_C3_12345678, 1'b1, 32'h1234_5678};
    tbl[2] = '{41'h1_5A_0000FFFF, 41'h1_FF_FFFFFFFF, 1'b0, 32'h1234_5678};
    tbl[3] = '{41'h0_81_FFFFFFFF, 41'h0_7E_80000001, 1'b1, 32'h8000_0001};

    spi_rst_n = 1'b0;
    upd();
    repeat (3) @(posedge spi_clk);
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en_a), 64'(0));
    chk("rst_sclk", 64'(sclk_a), 64'(0));
    chk("rst_cs_n", 64'(cs_n_a), 64'(1));
    chk("rst_mosi", 64'(mosi_a), 64'(0));
    chk("rst_rx_data", 64'(rx_data_a), 64'(0));
    chk("rst_rx_valid", 64'(rx_valid_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    spi_rst_n = 1'b1;

    repeat (100) tick();
    chk("idle_rd_en_cnt", 64'(rden_cnt_a), 64'(0));
    chk("idle_busy_cycles", 64'(busy_cyc_a), 64'(0));
    chk("idle_rx_valid_cnt", 64'(rxv_cnt_a), 64'(0));
    chk("idle_frames", 64'(fr_start_a), 64'(0));
    chk("idle_cs_n", 64'(cs_n_a), 64'(1));
    chk("idle_sclk", 64'(sclk_a), 64'(0));

    for (int i = 0; i < 4; i++) begin
      base = n_done_a;
      rv0  = rxv_cnt_a;
      rd0  = rden_cnt_a;
      push_a(tbl[i].word, tbl[i].resp, !tbl[i].word[40]);
      wait_frames_a(base + 1);
      chk_frame_a(base);
      chk($sformatf("vec%0d_rx_valid_pulses", i), 64'(rxv_cnt_a - rv0), 64'(tbl[i].exp_rxv));
      chk($sformatf("vec%0d_rx_data", i), 64'(rx_data_a), 64'(tbl[i].exp_rx));
      chk($sformatf("vec%0d_rd_en_pulses", i), 64'(rden_cnt_a - rd0), 64'(1));
    end

    // Three words queued at once: frames in FIFO order with minimal cs_n-high gaps
    base = n_done_a;
    rd0  = rden_cnt_a;
    push_a(41'h1_10_11111111, 41'h0, 1'b0);
    push_a(41'h0_20_22222222, 41'h1_55_9ABCDEF0, 1'b1);
    push_a(41'h1_30_33333333, 41'h0, 1'b0);
    wait_frames_a(base + 3);
    for (int k = 0; k < 3; k++) chk_frame_a(base + k);
    chk("b2b_gap1", 64'(gap_a[base+1]), 64'(6));
    chk("b2b_gap2", 64'(gap_a[base+2]), 64'(6));
    chk("b2b_rd_en_pulses", 64'(rden_cnt_a - rd0), 64'(3));

    // Random words with random spacing against the queue/array model
    base = n_done_a;
    for (int k = 0; k < 16; k++) begin
      w[40]    = 1'($urandom_range(0, 1));
      w[39:32] = 8'($urandom);
      w[31:0]  = 32'($urandom);
      r        = {9'($urandom), 32'($urandom)};
      push_a(w, r, !w[40]);
      repeat ($urandom_range(0, 10)) tick();
    end
    wait_frames_a(base + 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rand_bits_f%0d", base + k), fr_bits_a[base+k], {23'b0, word_a[base+k]});
      chk($sformatf("rand_len_f%0d", base + k), 64'(fr_len_a[base+k]), 64'(164));
    end

    // Fast instance: SCLK toggles every cycle, 82-cycle frame
    qb.push_back(41'h1_C3_5A5AA5A5);
    upd();
    budget = 400;
    while ((n_done_b < 1 || busy_b) && budget > 0) begin
      tick();
      budget--;
    end
    chk("fast_done", 64'(n_done_b >= 1 && !busy_b), 64'(1));
    chk("fast_bits", fb_bits_b, {23'b0, 41'h1_C3_5A5AA5A5});
    chk("fast_cs_low_len", 64'(fb_len_b), 64'(82));
    chk("fast_sclk_rises", 64'(fb_rises_b), 64'(41));
    chk("fast_sclk_toggle_misses", 64'(tog_bad_b), 64'(0));
    chk("fast_rd_en_pulses", 64'(rden_cnt_b), 64'(1));

    // Reset in the middle of a read frame: frame dropped, next word starts from bit 40
    base = n_done_a;
    rv0  = rxv_cnt_a;
    push_a(41'h0_77_00000000, 41'h0_00_ABCD1234, 1'b0);
    budget = 400;
    while (!(fr_start_a > base && cur_rises_a >= 21) && budget > 0) begin
      tick();
      budget--;
    end
    chk("abort_reached_bit20", 64'(fr_start_a > base && cur_rises_a >= 21), 64'(1));
    @(negedge spi_clk);
    #2;
    spi_rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 64'(cs_n_a), 64'(1));
    chk("abort_sclk", 64'(sclk_a), 64'(0));
    chk("abort_busy", 64'(busy_a), 64'(0));
    chk("abort_mosi", 64'(mosi_a), 64'(0));
    @(posedge spi_clk);
    #1;
    repeat (2) tick();
    spi_rst_n = 1'b1;
    push_a(41'h1_E7_0F0F0F0F, 41'h0, 1'b0);
    wait_frames_a(base + 2);
    chk_frame_a(base + 1);
    chk("abort_no_rx_valid", 64'(rxv_cnt_a - rv0), 64'(0));
    chk("abort_rx_data_cleared", 64'(rx_data_a), 64'(0));

    // Whole-run scoreboard
    chk("rx_valid_total", 64'(rxv_cnt_a), 64'(exp_n_a));
    for (int j = 0; j < exp_n_a; j++)
      chk($sformatf("rx_data_seq%0d", j), 64'(rxv_data_mon_a[j]), 64'(exp_rx_a[j]));
    chk("rx_valid_shape_errors", 64'(rxv_bad_a), 64'(0));
    chk("rd_en_rule_errors", 64'(rden_bad_a), 64'(0));
    chk("rd_en_total", 64'(rden_cnt_a), 64'(n_push_a));
    chk("mosi_change_off_falling_edge", 64'(mode_bad_a), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
